// File: rtl/video_arb_pkg.sv
// Shared types and constants for the video SDRAM port arbiter.
package video_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_CMD
  } state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_t;

  localparam int unsigned MAX_BURST = 8;

endpackage

// File: rtl/video_arb_outstanding_ctr.sv
// In-flight read beat counter: adds accepted burst lengths, subtracts returned
// beats (saturating at both ends) and reports whether a new burst still fits.
module video_arb_outstanding_ctr #(
  parameter int unsigned BURST_W = 4,
  parameter int unsigned MAX_OUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               add_en,
  input  logic [BURST_W-1:0] add_len,
  input  logic               sub_en,
  input  logic [BURST_W-1:0] req_len,
  output logic [CNT_W-1:0]   count,
  output logic               req_ok
);

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] SUM_ONE = SUM_W'(1);
  localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0] LIMIT   = SUM_W'(MAX_OUT);

  logic [SUM_W-1:0] count_ext;
  logic [SUM_W-1:0] sum_add;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] sum_req;

  always_comb begin
    count_ext = {2'b00, count};
    sum_add   = count_ext + (add_en ? SUM_W'(add_len) : '0);
    // A return with nothing in flight (stray valid) must not wrap below zero.
    sum_next  = (sub_en && (sum_add != '0)) ? (sum_add - SUM_ONE) : sum_add;
    if (sum_next > CNT_MAX) begin
      sum_next = CNT_MAX;
    end
    sum_req   = count_ext + SUM_W'(req_len);
    req_ok    = (sum_req <= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= sum_next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/video_sdram_arbiter.sv
// Two-master arbiter for the shared 16-bit SDRAM Avalon-MM port: video-in
// writer (master 0) and VGA pixel-buffer reader (master 1), granted per burst.
module video_sdram_arbiter
  import video_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BURST_W    = 4,
  parameter int unsigned MAX_RD_OUT = 16
) (
  input  logic               clk,
  input  logic               reset,

  input  logic [ADDR_W-1:0]  wr_address,
  input  logic               wr_write,
  input  logic [DATA_W-1:0]  wr_writedata,
  input  logic [BURST_W-1:0] wr_burstcount,
  output logic               wr_waitrequest,

  input  logic [ADDR_W-1:0]  rd_address,
  input  logic               rd_read,
  input  logic [BURST_W-1:0] rd_burstcount,
  input  logic               rd_urgent,
  output logic               rd_waitrequest,
  output logic [DATA_W-1:0]  rd_readdata,
  output logic               rd_readdatavalid,

  output logic [ADDR_W-1:0]  s_address,
  output logic               s_write,
  output logic               s_read,
  output logic [DATA_W-1:0]  s_writedata,
  output logic [BURST_W-1:0] s_burstcount,
  input  logic               s_waitrequest,
  input  logic [DATA_W-1:0]  s_readdata,
  input  logic               s_readdatavalid,

  output logic [4:0]         rd_outstanding
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

  state_t              state, state_nxt;
  grant_t              last_grant, last_grant_nxt;
  logic [BEAT_W-1:0]   beats_left, beats_left_nxt;
  logic                rd_room;
  logic                rd_ok;
  logic                rd_accept;

  video_arb_outstanding_ctr #(
    .BURST_W (BURST_W),
    .MAX_OUT (MAX_RD_OUT),
    .CNT_W   (5)
  ) u_outstanding (
    .clk     (clk),
    .reset   (reset),
    .add_en  (rd_accept),
    .add_len (rd_burstcount),
    .sub_en  (s_readdatavalid),
    .req_len (rd_burstcount),
    .count   (rd_outstanding),
    .req_ok  (rd_room)
  );

  assign rd_ok            = rd_read && rd_room;
  assign rd_readdata      = s_readdata;
  assign rd_readdatavalid = s_readdatavalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_RD;
      beats_left <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beats_left <= beats_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beats_left_nxt = beats_left;
    rd_accept      = 1'b0;
    s_address      = '0;
    s_write        = 1'b0;
    s_read         = 1'b0;
    s_writedata    = '0;
    s_burstcount   = '0;
    wr_waitrequest = 1'b1;
    rd_waitrequest = 1'b1;

    unique case (state)
      IDLE: begin
        // Urgency wins only when the reader FIFO can actually absorb the burst.
        if (rd_urgent && rd_ok) begin
          state_nxt = RD_CMD;
        end else if (wr_write && rd_ok) begin
          state_nxt = (last_grant == GNT_RD) ? WR_BURST : RD_CMD;
        end else if (wr_write) begin
          state_nxt = WR_BURST;
        end else if (rd_ok) begin
          state_nxt = RD_CMD;
        end
        if (state_nxt == WR_BURST) begin
          beats_left_nxt = (wr_burstcount == '0) ? BEAT_ONE : BEAT_W'(wr_burstcount);
        end
      end

      WR_BURST: begin
        s_address      = wr_address;
        s_write        = wr_write;
        s_writedata    = wr_write ? wr_writedata : '0;
        s_burstcount   = wr_burstcount;
        wr_waitrequest = s_waitrequest;
        if (wr_write && !s_waitrequest) begin
          beats_left_nxt = beats_left - BEAT_ONE;
          if (beats_left <= BEAT_ONE) begin
            state_nxt      = IDLE;
            last_grant_nxt = GNT_WR;
          end
        end
      end

      RD_CMD: begin
        s_address      = rd_address;
        s_read         = rd_read;
        s_burstcount   = rd_burstcount;
        rd_waitrequest = s_waitrequest;
        if (rd_read && !s_waitrequest) begin
          rd_accept      = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = GNT_RD;
        end else if (!rd_read) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_video_sdram_arbiter.sv
// Directed and randomized checks of the video SDRAM arbiter against a
// transaction-level model of grants and in-flight read beats.
module tb_video_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] wr_address;
  logic        wr_write;
  logic [15:0] wr_writedata;
  logic [3:0]  wr_burstcount;
  logic        wr_waitrequest;
  logic [31:0] rd_address;
  logic        rd_read;
  logic [3:0]  rd_burstcount;
  logic        rd_urgent;
  logic        rd_waitrequest;
  logic [15:0] rd_readdata;
  logic        rd_readdatavalid;
  logic [31:0] s_address;
  logic        s_write;
  logic        s_read;
  logic [15:0] s_writedata;
  logic [3:0]  s_burstcount;
  logic        s_waitrequest;
  logic [15:0] s_readdata;
  logic        s_readdatavalid;
  logic [4:0]  rd_outstanding;

  int n_tests;
  int n_fail;

  video_sdram_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (16),
    .BURST_W    (4),
    .MAX_RD_OUT (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_address       (wr_address),
    .wr_write         (wr_write),
    .wr_writedata     (wr_writedata),
    .wr_burstcount    (wr_burstcount),
    .wr_waitrequest   (wr_waitrequest),
    .rd_address       (rd_address),
    .rd_read          (rd_read),
    .rd_burstcount    (rd_burstcount),
    .rd_urgent        (rd_urgent),
    .rd_waitrequest   (rd_waitrequest),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .s_address        (s_address),
    .s_write          (s_write),
    .s_read           (s_read),
    .s_writedata      (s_writedata),
    .s_burstcount     (s_burstcount),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .rd_outstanding   (rd_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    wr_address = '0; wr_write = 0; wr_writedata = '0; wr_burstcount = '0;
    rd_address = '0; rd_read = 0; rd_burstcount = '0; rd_urgent = 0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      s_readdatavalid = 1;
      s_readdata = 16'($urandom);
      smp();
      chk("ret_valid", rd_readdatavalid, 1);
      chk("ret_data", rd_readdata, s_readdata);
      tick();
    end
    s_readdatavalid = 0;
  endtask

  // Random-phase model state
  int  model_out;
  int  model_last;   // 0 = writer finished last, 1 = reader
  int  pend;         // predicted owner next cycle: 0 WR, 1 RD, 2 none, -1 unknown
  int  wr_left;
  int  acc_add;
  bit  wr_act, rd_act, wr_adv, wr_end, rd_end, ok;
  logic [15:0] wr_next;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset state
    do_reset();
    smp();
    chk("rst_wr_wait", wr_waitrequest, 1);
    chk("rst_rd_wait", rd_waitrequest, 1);
    chk("rst_s_write", s_write, 0);
    chk("rst_s_read", s_read, 0);
    chk("rst_outstanding", rd_outstanding, 0);
    tick();

    // Write-only burst of 4
    wr_address = 32'h100; wr_burstcount = 4; wr_writedata = 16'hA000; wr_write = 1;
    smp();
    chk("t1_req_wait", wr_waitrequest, 1);
    chk("t1_req_idle", s_write, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      smp();
      chk("t1_s_write", s_write, 1);
      chk("t1_s_data", s_writedata, 16'hA000 + 16'(b));
      chk("t1_s_addr", s_address, 32'h100);
      chk("t1_wr_wait", wr_waitrequest, 0);
      chk("t1_rd_wait", rd_waitrequest, 1);
      tick();
      wr_writedata = 16'hA001 + 16'(b);
      if (b == 3) wr_write = 0;
    end
    smp();
    chk("t1_end_idle", s_write, 0);
    chk("t1_end_wait", wr_waitrequest, 1);
    tick();

    // Burstcount 0 behaves as a single beat
    wr_burstcount = 0; wr_write = 1;
    tick();
    smp();
    chk("t1b_beat", s_write, 1);
    tick();
    wr_burstcount = 1;
    smp();
    chk("t1b_back_idle", s_write, 0);
    tick();
    smp();
    chk("t1b_next_grant", s_write, 1);
    tick();
    wr_write = 0;

    // Alternation on simultaneous requests
    do_reset();
    wr_address = 32'h200; wr_burstcount = 2; wr_writedata = 16'hB000; wr_write = 1;
    rd_address = 32'h300; rd_burstcount = 2; rd_read = 1;
    smp();
    chk("t2_idle_w", s_write, 0);
    chk("t2_idle_r", s_read, 0);
    tick();
    smp();
    chk("t2_wr_first", s_write, 1);
    chk("t2_rd_held", s_read, 0);
    chk("t2_rd_wait", rd_waitrequest, 1);
    tick();
    wr_writedata = 16'hB001;
    smp();
    chk("t2_wr_beat2", s_write, 1);
    tick();
    wr_write = 0;
    smp();
    chk("t2_gap", s_read, 0);
    tick();
    smp();
    chk("t2_rd_second", s_read, 1);
    chk("t2_rd_addr", s_address, 32'h300);
    chk("t2_rd_wait_lo", rd_waitrequest, 0);
    chk("t2_wr_wait_hi", wr_waitrequest, 1);
    tick();
    rd_read = 0;
    wr_write = 1; wr_burstcount = 1; rd_read = 1; rd_burstcount = 1;
    smp();
    chk("t2_outstanding", rd_outstanding, 2);
    tick();
    smp();
    chk("t2_wr_again", s_write, 1);
    chk("t2_rd_not", s_read, 0);
    tick();
    wr_write = 0;
    tick();
    smp();
    chk("t2_rd_again", s_read, 1);
    tick();
    rd_read = 0;
    drain(3);
    smp();
    chk("t2_drained", rd_outstanding, 0);
    tick();

    // Urgency in IDLE, and no pre-emption of a running write burst
    do_reset();
    wr_address = 32'h400; wr_burstcount = 8; wr_writedata = 16'hC000; wr_write = 1;
    rd_address = 32'h480; rd_burstcount = 2; rd_read = 1; rd_urgent = 1;
    smp();
    chk("t3_idle", s_write, 0);
    tick();
    smp();
    chk("t3_urgent_rd", s_read, 1);
    chk("t3_wr_held", s_write, 0);
    tick();
    rd_read = 0; rd_urgent = 0;
    tick();
    for (int b = 0; b < 8; b++) begin
      if (b == 1) begin
        rd_read = 1; rd_urgent = 1;
      end
      if (b == 2) begin
        s_waitrequest = 1;
        smp();
        chk("t3_stall_wait", wr_waitrequest, 1);
        chk("t3_stall_data", s_writedata, 16'hC002);
        tick();
        s_waitrequest = 0;
      end
      smp();
      chk("t3_wr_beat", s_write, 1);
      chk("t3_wr_data", s_writedata, 16'hC000 + 16'(b));
      chk("t3_rd_wait", rd_waitrequest, 1);
      tick();
      wr_writedata = 16'hC001 + 16'(b);
      if (b == 7) wr_write = 0;
    end
    smp();
    chk("t3_after_idle_w", s_write, 0);
    chk("t3_after_idle_r", s_read, 0);
    tick();
    smp();
    chk("t3_rd_after", s_read, 1);
    tick();
    rd_read = 0; rd_urgent = 0;
    drain(4);

    // Outstanding limit
    do_reset();
    rd_address = 32'h500; rd_burstcount = 8; rd_read = 1;
    tick();
    smp();
    chk("t4_rd1", s_read, 1);
    tick();
    rd_address = 32'h510;
    smp();
    chk("t4_out8", rd_outstanding, 8);
    tick();
    smp();
    chk("t4_rd2", s_read, 1);
    tick();
    rd_address = 32'h520; rd_urgent = 1;
    wr_address = 32'h600; wr_burstcount = 1; wr_write = 1;
    smp();
    chk("t4_out16", rd_outstanding, 16);
    chk("t4_blocked_rd", s_read, 0);
    chk("t4_blocked_wait", rd_waitrequest, 1);
    tick();
    smp();
    chk("t4_wr_while_full", s_write, 1);
    chk("t4_rd_wait_wr", rd_waitrequest, 1);
    tick();
    wr_write = 0;
    for (int v = 0; v < 8; v++) begin
      s_readdatavalid = 1;
      s_readdata = 16'h7700 + 16'(v);
      smp();
      chk("t4_drain_cnt", rd_outstanding, 32'(16 - v));
      chk("t4_drain_hold", s_read, 0);
      chk("t4_drain_wait", rd_waitrequest, 1);
      chk("t4_ret_data", rd_readdata, 16'h7700 + 16'(v));
      tick();
    end
    s_readdatavalid = 0;
    smp();
    chk("t4_out8_again", rd_outstanding, 8);
    chk("t4_still_idle", s_read, 0);
    tick();
    smp();
    chk("t4_third_granted", s_read, 1);
    chk("t4_third_addr", s_address, 32'h520);
    tick();
    rd_read = 0; rd_urgent = 0;
    drain(16);
    smp();
    chk("t4_empty", rd_outstanding, 0);
    tick();

    // Accept and return in the same cycle, with a slave stall first
    do_reset();
    rd_burstcount = 3; rd_read = 1;
    tick();
    tick();
    rd_burstcount = 4;
    smp();
    chk("t5_out3", rd_outstanding, 3);
    tick();
    s_waitrequest = 1;
    smp();
    chk("t5_stall_read", s_read, 1);
    chk("t5_stall_wait", rd_waitrequest, 1);
    tick();
    s_waitrequest = 0; s_readdatavalid = 1;
    smp();
    chk("t5_accept_wait", rd_waitrequest, 0);
    tick();
    rd_read = 0; s_readdatavalid = 0;
    smp();
    chk("t5_accept_and_return", rd_outstanding, 6);
    tick();
    drain(6);

    // Stray return after reset does not underflow
    do_reset();
    s_readdatavalid = 1;
    tick();
    s_readdatavalid = 0;
    smp();
    chk("t6_no_underflow", rd_outstanding, 0);
    tick();

    // Reset during the third beat of a write burst
    rd_burstcount = 2; rd_read = 1;
    tick();
    tick();
    rd_read = 0;
    wr_burstcount = 4; wr_write = 1;
    tick();
    tick();
    tick();
    reset = 1;
    smp();
    chk("t7_beat3", s_write, 1);
    chk("t7_out_before", rd_outstanding, 2);
    tick();
    smp();
    chk("t7_s_write", s_write, 0);
    chk("t7_wr_wait", wr_waitrequest, 1);
    chk("t7_rd_wait", rd_waitrequest, 1);
    chk("t7_outstanding", rd_outstanding, 0);
    tick();
    reset = 0; wr_write = 0;

    // Randomized traffic against the transaction model
    do_reset();
    model_out = 0; model_last = 1; pend = -1;
    wr_act = 0; rd_act = 0; wr_left = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!wr_act && $urandom_range(0, 3) == 0) begin
        wr_act = 1;
        wr_write = 1;
        wr_burstcount = 4'($urandom_range(0, 8));
        wr_left = (wr_burstcount == 0) ? 1 : int'(wr_burstcount);
        wr_address = $urandom;
        wr_writedata = 16'($urandom);
      end
      if (!rd_act && $urandom_range(0, 3) == 0) begin
        rd_act = 1;
        rd_read = 1;
        rd_burstcount = 4'($urandom_range(1, 8));
        rd_address = $urandom;
      end
      rd_urgent = rd_act && ($urandom_range(0, 2) == 0);
      s_waitrequest = ($urandom_range(0, 3) == 0);
      s_readdatavalid = (model_out > 0) && ($urandom_range(0, 1) == 1);
      s_readdata = 16'($urandom);

      smp();
      chk("r_outstanding", rd_outstanding, model_out);
      if (pend >= 0) begin
        chk("r_grant_wr", s_write, pend == 0);
        chk("r_grant_rd", s_read, pend == 1);
      end
      chk("r_excl", s_write & s_read, 0);
      chk("r_ret_valid", rd_readdatavalid, s_readdatavalid);
      if (s_readdatavalid) chk("r_ret_data", rd_readdata, s_readdata);
      if (s_write) begin
        chk("r_rd_stall", rd_waitrequest, 1);
        chk("r_wr_wait", wr_waitrequest, s_waitrequest);
        chk("r_wr_data", s_writedata, wr_writedata);
        chk("r_wr_addr", s_address, wr_address);
      end
      if (s_read) begin
        chk("r_wr_stall", wr_waitrequest, 1);
        chk("r_rd_wait", rd_waitrequest, s_waitrequest);
        chk("r_rd_len", s_burstcount, rd_burstcount);
      end
      if (!s_write && !s_read) begin
        chk("r_idle_wwait", wr_waitrequest, 1);
        chk("r_idle_rwait", rd_waitrequest, 1);
        ok = rd_read && (model_out + int'(rd_burstcount) <= 16);
        if (rd_urgent && ok) pend = 1;
        else if (wr_write && ok) pend = (model_last == 1) ? 0 : 1;
        else if (wr_write) pend = 0;
        else if (ok) pend = 1;
        else pend = 2;
      end else begin
        pend = -1;
      end

      wr_adv = 0; wr_end = 0; rd_end = 0; acc_add = 0;
      if (wr_write && !wr_waitrequest) begin
        wr_adv = 1;
        wr_next = 16'($urandom);
        wr_left--;
        if (wr_left == 0) begin
          wr_end = 1;
          model_last = 0;
        end
      end
      if (rd_read && !rd_waitrequest) begin
        acc_add = int'(rd_burstcount);
        rd_end = 1;
        model_last = 1;
      end
      model_out = model_out + acc_add - (s_readdatavalid ? 1 : 0);
      if (model_out < 0) model_out = 0;

      tick();
      if (wr_adv) wr_writedata = wr_next;
      if (wr_end) begin
        wr_write = 0;
        wr_act = 0;
      end
      if (rd_end) begin
        rd_read = 0;
        rd_act = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_sdram_arbiter.md
Name: video_sdram_arbiter

Overview:
Shares the single 16-bit SDRAM Avalon-MM port between two masters. Master 0 is the video-in frame writer (write-only). Master 1 is the VGA pixel-buffer reader (read-only). Grants are issued per burst; a VGA urgency input overrides round-robin fairness. A bounded outstanding-read counter keeps read data within the reader FIFO's capacity. The block sits between the video DMA masters and the SDRAM controller slave inside Computer_System.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 16, data width (SDRAM dq width)
BURST_W, 4, burstcount width; maximum legal burst is 8
MAX_RD_OUT, 16, maximum read beats in flight (reader FIFO headroom)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_address  in  ADDR_W  master 0 address
wr_write  in  1  master 0 write request/beat
wr_writedata  in  DATA_W  master 0 data
wr_burstcount  in  BURST_W  master 0 burst length, sampled on first beat
wr_waitrequest  out  1  master 0 stall
rd_address  in  ADDR_W  master 1 address
rd_read  in  1  master 1 read request
rd_burstcount  in  BURST_W  master 1 burst length
rd_urgent  in  1  reader FIFO below low watermark
rd_waitrequest  out  1  master 1 stall
rd_readdata  out  DATA_W  routed read data
rd_readdatavalid  out  1  routed read valid
s_address  out  ADDR_W  to SDRAM controller
s_write, s_read  out  1 each  command strobes
s_writedata  out  DATA_W
s_burstcount  out  BURST_W
s_waitrequest  in  1
s_readdata  in  DATA_W
s_readdatavalid  in  1
rd_outstanding  out  5  current in-flight read beats (debug)

Behaviour:
- Reset (synchronous): state IDLE; last_grant=RD, so WR wins the first tie; outstanding=0; beat counter=0; all s_* strobes 0; wr_waitrequest=rd_waitrequest=1.
- States:
  - IDLE: arbitrate on registered request sampling.
  - WR_BURST: master 0 owns the port.
  - RD_CMD: master 1 owns the port for one command.
- Arbitration, evaluated in IDLE only:
  - rd_ok = rd_read && (outstanding + rd_burstcount <= MAX_RD_OUT).
  - If rd_urgent && rd_ok, grant RD.
  - Else if both wr_write and rd_ok, grant the one not equal to last_grant.
  - Else grant whichever requests; if none, stay in IDLE.
  - A grant takes effect the next cycle. Request-to-s_* latency is 1 cycle.
- WR_BURST:
  - s_* mirror master 0 combinationally; wr_waitrequest = s_waitrequest.
  - beats_left is loaded from wr_burstcount at entry and decrements on each accepted beat (s_write && !s_waitrequest).
  - At 0, return to IDLE and set last_grant=WR.
  - A burstcount of 0 is treated as 1.
  - rd_urgent does not pre-empt an in-progress write burst.
- RD_CMD:
  - s_read/s_address/s_burstcount mirror master 1.
  - When the command is accepted (!s_waitrequest): outstanding += burstcount, last_grant=RD, return to IDLE.
- Stall rule: the non-granted master always sees waitrequest=1. In IDLE both see 1.
- Read return: rd_readdata/rd_readdatavalid = s_readdata/s_readdatavalid, passed through combinationally in every state.
  - Each valid beat decrements outstanding.
  - An accept and a return in the same cycle apply both: outstanding += burstcount - 1.
  - outstanding saturates at 0; a stray valid after reset does not underflow.
- rd_ok false (limit reached) blocks RD even when urgent; WR may be granted meanwhile.
- Reset mid-burst: port released immediately, strobes 0 on the next edge. The masters are reset by the same signal.
- s_writedata is don't-care when s_write=0. Drive 0 so waves stay clean.

Decomposition:
- Package video_arb_pkg:
  - state enum {IDLE, WR_BURST, RD_CMD}
  - grant enum {GNT_WR, GNT_RD}
  - MAX_BURST=8 constant
- One sub-module, video_arb_outstanding_ctr: the saturating add/sub counter with a limit-check output.
- Mux and FSM stay in the top level.

Test Plan:
- Write only, burst 4, s_waitrequest=0 -> s_write high cycles 2-5 after the request, 4 beats forwarded, then IDLE; rd_waitrequest=1 throughout.
- wr and rd requested in the same cycle after reset, neither urgent -> WR granted first (burst 2), then RD; the next simultaneous request grants WR again, proving alternation.
- rd_urgent=1 while wr also requests, in IDLE -> RD granted first; asserting urgent during a WR burst of 8 does not cut the burst short.
- Two RD bursts of 8 accepted with no readdatavalid -> outstanding=16; a third rd_read is held (rd_waitrequest=1) until a valid returns, after which it still waits until outstanding <= 8.
- Read accepted (burst 4) in the same cycle as a readdatavalid with outstanding=3 -> outstanding=6.
- Reset asserted during the 3rd beat of a write burst -> next cycle s_write=0, both waitrequests=1, outstanding=0, state IDLE.
